// File: rtl/add32_sched_pkg.sv
// Shared definitions for the add32 request scheduler: default widths,
// requester id width and the tag carried alongside each adder operation.
package add32_sched_pkg;

    localparam int unsigned W_DEF   = 32;
    localparam int unsigned LAT_DEF = 4;
    localparam int unsigned ID_W    = 1;
    localparam int unsigned N_REQ   = 2;

    // One tag per adder stage: whether the stage holds a live request and who owns it.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/add32_rr_arb.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   valid         per-requester request valid
//   advance       1 when a grant may be issued this cycle
//   grant         one-hot grant (zero when nothing is granted)
//   last_grant    id of the most recently granted requester
module add32_rr_arb
    import add32_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] valid,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic             last_grant
);

    logic last_q;
    logic last_d;

    // Grant selection; a tie goes to the requester that was not granted last.
    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        if (advance) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
        // A grant always lands on a valid requester, so it is a transfer.
        if (grant != 2'b00) begin
            last_d = grant[1];
        end
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_grant = last_q;

endmodule

// File: rtl/add32_sched.sv
// Schedules two requesters onto one shared pipelined adder and routes results back.
// A tag pipeline of depth LAT moves in lockstep with the adder stages so each
// result leaving the adder is paired with the requester that issued it.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   req_valid/req_ready             per-requester request handshake
//   req_a0/req_b0, req_a1/req_b1    operands of requester 0 / 1
//   req_cin                         carry-in per requester
//   add_a/add_b/add_cin             operands driven to the shared adder
//   add_stop                        freezes every adder stage
//   add_sum/add_cout                adder result
//   resp_valid/resp_ready           response handshake
//   resp_id/resp_sum/resp_cout      response owner and result
//   busy                            any request in flight
module add32_sched
    import add32_sched_pkg::*;
#(
    parameter int unsigned W   = W_DEF,
    parameter int unsigned LAT = LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    input  logic [W-1:0]     req_a0,
    input  logic [W-1:0]     req_b0,
    input  logic [W-1:0]     req_a1,
    input  logic [W-1:0]     req_b1,
    input  logic [N_REQ-1:0] req_cin,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    output logic             add_cin,
    output logic             add_stop,
    input  logic [W-1:0]     add_sum,
    input  logic             add_cout,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [W-1:0]     resp_sum,
    output logic             resp_cout,
    output logic             busy
);

    tag_t             tag_q [LAT];
    tag_t             tag_d [LAT];
    logic             advance;
    logic [N_REQ-1:0] grant;
    logic             last_grant;

    // A response held at the adder output stalls everything behind it.
    assign add_stop = tag_q[LAT-1].valid & ~resp_ready;
    // Held low in reset so no request is accepted or driven to the adder.
    assign advance  = rst & ~add_stop;

    add32_rr_arb u_arb (
        .clk        (clk),
        .rst        (rst),
        .valid      (req_valid),
        .advance    (advance),
        .grant      (grant),
        .last_grant (last_grant)
    );

    assign req_ready = grant;

    // Operand mux to the shared adder; zero when nothing is granted.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (grant[0]) begin
            add_a   = req_a0;
            add_b   = req_b0;
            add_cin = req_cin[0];
        end else if (grant[1]) begin
            add_a   = req_a1;
            add_b   = req_b1;
            add_cin = req_cin[1];
        end
    end

    // Tag pipeline next state: shift on unstalled cycles, hold otherwise.
    always_comb begin
        tag_d = tag_q;
        if (advance) begin
            tag_d[0].valid = |grant;
            tag_d[0].id    = ID_W'(grant[1]);
            for (int unsigned k = 1; k < LAT; k++) begin
                tag_d[k] = tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    // In-flight indicator across all stages.
    always_comb begin
        busy = 1'b0;
        for (int unsigned k = 0; k < LAT; k++) begin
            busy = busy | tag_q[k].valid;
        end
    end

    assign resp_valid = tag_q[LAT-1].valid;
    assign resp_id    = tag_q[LAT-1].id;
    assign resp_sum   = add_sum;
    assign resp_cout  = add_cout;

endmodule
